// File: rtl/ahbl_pkg.sv
// Shared AHB-Lite encodings and the command record
// used by the master port and its command FIFO.
package ahbl_pkg;

    localparam int CMD_AW = 32;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [2:0] {
        HSIZE_BYTE = 3'b000,
        HSIZE_HALF = 3'b001,
        HSIZE_WORD = 3'b010
    } hsize_e;

    typedef struct packed {
        logic [CMD_AW-1:0] addr;
        logic              write;
        logic [1:0]        size;
        logic [31:0]       wdata;
    } ahbl_cmd_t;

    // Size 3 has no meaning on a 32-bit bus; treat it as a word.
    function automatic logic [1:0] coerce_size(input logic [1:0] s);
        return (s == 2'd3) ? 2'd2 : s;
    endfunction

    // Clear the low address bits implied by the transfer size.
    function automatic logic [CMD_AW-1:0] align_addr(
        input logic [CMD_AW-1:0] a,
        input logic [1:0]        s
    );
        logic [CMD_AW-1:0] r;
        r = a;
        if (s == 2'd1)
            r[0] = 1'b0;
        else if (s == 2'd2)
            r[1:0] = 2'b00;
        return r;
    endfunction

endpackage

// File: rtl/ahbl_master_port_if.sv
// Command, AHB-Lite bus and response signals of the master port.
// The master modport is the port's view; slave is the environment's.
interface ahbl_master_port_if #(
    parameter int AW = 32
);
    logic          cmd_valid;
    logic          cmd_ready;
    logic [AW-1:0] cmd_addr;
    logic          cmd_write;
    logic [1:0]    cmd_size;
    logic [31:0]   cmd_wdata;

    logic [AW-1:0] HADDR;
    logic [1:0]    HTRANS;
    logic          HWRITE;
    logic [2:0]    HSIZE;
    logic [31:0]   HWDATA;
    logic          HREADY;
    logic [31:0]   HRDATA;
    logic          HRESP;

    logic          rsp_valid;
    logic [31:0]   rsp_rdata;
    logic          rsp_err;
    logic          busy;

    modport master (
        input  cmd_valid, cmd_addr, cmd_write,
        input  cmd_size, cmd_wdata,
        output cmd_ready,
        output HADDR, HTRANS, HWRITE, HSIZE, HWDATA,
        input  HREADY, HRDATA, HRESP,
        output rsp_valid, rsp_rdata, rsp_err, busy
    );

    modport slave (
        output cmd_valid, cmd_addr, cmd_write,
        output cmd_size, cmd_wdata,
        input  cmd_ready,
        input  HADDR, HTRANS, HWRITE, HSIZE, HWDATA,
        output HREADY, HRDATA, HRESP,
        input  rsp_valid, rsp_rdata, rsp_err, busy
    );
endinterface

// File: rtl/ahbl_cmd_fifo.sv
// Synchronous command FIFO, power-of-two depth, async high reset.
// Head entry is presented combinationally on rdata.
module ahbl_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW:0]      wr_ptr;
    logic [PW:0]      rd_ptr;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PW] != rd_ptr[PW]) &&
                   (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign rdata = mem[rd_ptr[PW-1:0]];

    // Storage needs no reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push && !full)
            mem[wr_ptr[PW-1:0]] <= wdata;
    end

    // Pointer update; reset flushes the contents.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop && !empty)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end
endmodule

// File: rtl/ahbl_master_port.sv
// AHB-Lite initiator: command FIFO -> address reg A -> data reg D -> rsp.
// Optional ERROR handling is built when AHBL_MASTER_ERR_EN is defined.
module ahbl_master_port
    import ahbl_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int AW         = 32
) (
    input  logic                HCLK,
    input  logic                HRESET,
    ahbl_master_port_if.master  bus
);
    localparam int CW = $bits(ahbl_cmd_t);

    ahbl_cmd_t   push_cmd;
    ahbl_cmd_t   head;
    logic        fifo_full;
    logic        fifo_empty;
    logic        push;
    logic        pop;

    logic        a_valid;
    ahbl_cmd_t   a_cmd;
    logic        d_valid;
    logic        d_write;
    logic [31:0] d_wdata;

    logic        cancel;
    logic        err;
    logic        a_adv;
    logic        d_done;

`ifdef AHBL_MASTER_ERR_EN
    // While D is in an ERROR response, keep A off the bus and in place.
    assign cancel = d_valid && bus.HRESP;
    assign err    = bus.HRESP;
`else
    logic unused_hresp;
    assign unused_hresp = bus.HRESP;
    assign cancel       = 1'b0;
    assign err          = 1'b0;
`endif

    assign push   = bus.cmd_valid && !fifo_full;
    assign a_adv  = (!a_valid || bus.HREADY) && !cancel;
    assign pop    = a_adv && !fifo_empty;
    assign d_done = d_valid && bus.HREADY;

    // Normalise size and alignment once, on the way into the FIFO.
    always_comb begin
        push_cmd       = '0;
        push_cmd.size  = coerce_size(bus.cmd_size);
        push_cmd.addr  = align_addr(CMD_AW'(bus.cmd_addr), push_cmd.size);
        push_cmd.write = bus.cmd_write;
        push_cmd.wdata = bus.cmd_wdata;
    end

    ahbl_cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (CW)
    ) u_fifo (
        .clk   (HCLK),
        .rst   (HRESET),
        .push  (push),
        .wdata (push_cmd),
        .pop   (pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Address phase: fields are kept when A drains so the bus holds them.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            a_valid <= 1'b0;
            a_cmd   <= '0;
        end else if (a_adv) begin
            a_valid <= !fifo_empty;
            if (!fifo_empty)
                a_cmd <= head;
        end
    end

    // Data phase: an accepted address phase moves in on HREADY.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            d_valid <= 1'b0;
            d_write <= 1'b0;
            d_wdata <= '0;
        end else if (bus.HREADY) begin
            d_valid <= a_valid && !cancel;
            if (a_valid && !cancel) begin
                d_write <= a_cmd.write;
                d_wdata <= a_cmd.wdata;
            end
        end
    end

    // Response: one pulse the cycle after the data phase completes.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            bus.rsp_valid <= 1'b0;
            bus.rsp_rdata <= '0;
            bus.rsp_err   <= 1'b0;
        end else begin
            bus.rsp_valid <= d_done;
            bus.rsp_err   <= d_done && err;
            if (d_done && !d_write && !err)
                bus.rsp_rdata <= bus.HRDATA;
            else
                bus.rsp_rdata <= '0;
        end
    end

    assign bus.cmd_ready = !fifo_full;
    assign bus.HTRANS    = (a_valid && !cancel) ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign bus.HADDR     = AW'(a_cmd.addr);
    assign bus.HWRITE    = a_cmd.write;
    assign bus.HSIZE     = {1'b0, a_cmd.size};
    assign bus.HWDATA    = d_wdata;
    assign bus.busy      = !fifo_empty || a_valid ||
                           d_valid || bus.rsp_valid;
endmodule

// File: tb/tb_ahbl_master_port.sv
// Directed bench for ahbl_master_port with a tiny slave model
// that returns the data-phase address as HRDATA.
module tb_ahbl_master_port;
    import ahbl_pkg::*;

    logic HCLK = 1'b0;
    logic HRESET;
    int   n_chk = 0;
    int   n_err = 0;

    always #5 HCLK = ~HCLK;

    ahbl_master_port_if #(.AW(32)) bus ();

    ahbl_master_port #(
        .FIFO_DEPTH (4),
        .AW         (32)
    ) dut (
        .HCLK   (HCLK),
        .HRESET (HRESET),
        .bus    (bus)
    );

    logic [31:0] dp_addr;

    always @(posedge HCLK or posedge HRESET) begin
        if (HRESET)
            dp_addr <= '0;
        else if (bus.HREADY && bus.HTRANS == 2'b10)
            dp_addr <= bus.HADDR;
    end
    assign bus.HRDATA = dp_addr;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge HCLK);
        #1;
    endtask

    task automatic drive(input logic [31:0] a, input logic w,
                         input logic [1:0] s, input logic [31:0] d);
        bus.cmd_valid = 1'b1;
        bus.cmd_addr  = a;
        bus.cmd_write = w;
        bus.cmd_size  = s;
        bus.cmd_wdata = d;
    endtask

    task automatic idle_cmd;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 50 && bus.busy; i++)
            tick;
        chk(tag, bus.busy, 0);
    endtask

    int acc;
    int got;

    initial begin
        HRESET        = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_write = 1'b0;
        bus.cmd_size  = 2'd0;
        bus.cmd_wdata = '0;
        bus.HREADY    = 1'b1;
        bus.HRESP     = 1'b0;
        tick;
        tick;
        chk("rst_htrans", bus.HTRANS, 0);
        chk("rst_haddr", bus.HADDR, 0);
        chk("rst_hwdata", bus.HWDATA, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_rsp", bus.rsp_valid, 0);
        chk("rst_ready", bus.cmd_ready, 1);
        HRESET = 1'b0;
        tick;

        // single write, zero wait
        drive(32'h2000_0004, 1'b1, 2'd2, 32'hDEAD_BEEF);
        tick;
        idle_cmd;
        chk("t1_e0_htrans", bus.HTRANS, 0);
        chk("t1_e0_busy", bus.busy, 1);
        tick;
        chk("t1_htrans", bus.HTRANS, 2);
        chk("t1_haddr", bus.HADDR, 32'h2000_0004);
        chk("t1_hwrite", bus.HWRITE, 1);
        chk("t1_hsize", bus.HSIZE, 2);
        tick;
        chk("t1_hwdata", bus.HWDATA, 32'hDEAD_BEEF);
        chk("t1_e2_htrans", bus.HTRANS, 0);
        chk("t1_e2_rsp", bus.rsp_valid, 0);
        tick;
        chk("t1_rsp", bus.rsp_valid, 1);
        chk("t1_err", bus.rsp_err, 0);
        chk("t1_rdata", bus.rsp_rdata, 0);
        tick;
        chk("t1_rsp_pulse", bus.rsp_valid, 0);
        chk("t1_idle_busy", bus.busy, 0);
        chk("t1_hold_haddr", bus.HADDR, 32'h2000_0004);

        // alignment and size coercion
        drive(32'h0000_1003, 1'b0, 2'd3, 32'h0);
        tick;
        drive(32'h0000_2007, 1'b0, 2'd1, 32'h0);
        tick;
        idle_cmd;
        chk("al_haddr_w", bus.HADDR, 32'h0000_1000);
        chk("al_hsize_w", bus.HSIZE, 2);
        tick;
        chk("al_haddr_h", bus.HADDR, 32'h0000_2006);
        chk("al_hsize_h", bus.HSIZE, 1);
        drain("al_drain");

        // four back-to-back reads
        for (int c = 0; c < 8; c++) begin
            if (c < 4)
                drive(32'(c * 4), 1'b0, 2'd2, 32'h0);
            else
                idle_cmd;
            tick;
            if (c >= 1 && c <= 4) begin
                chk("t2_htrans", bus.HTRANS, 2);
                chk("t2_haddr", bus.HADDR, 32'((c - 1) * 4));
            end
            if (c >= 3 && c <= 6) begin
                chk("t2_rsp", bus.rsp_valid, 1);
                chk("t2_rdata", bus.rsp_rdata, 32'((c - 3) * 4));
            end
        end
        drain("t2_drain");

        // two wait states on the second read
        for (int c = 0; c < 8; c++) begin
            if (c == 0)
                drive(32'h100, 1'b0, 2'd2, 32'h0);
            else if (c == 1)
                drive(32'h104, 1'b0, 2'd2, 32'h0);
            else
                idle_cmd;
            tick;
            case (c)
                1: begin
                    chk("t3_ns1", bus.HTRANS, 2);
                    chk("t3_a1", bus.HADDR, 32'h100);
                end
                2: begin
                    chk("t3_ns2", bus.HTRANS, 2);
                    chk("t3_a2", bus.HADDR, 32'h104);
                end
                3: begin
                    chk("t3_rsp1", bus.rsp_valid, 1);
                    chk("t3_rd1", bus.rsp_rdata, 32'h100);
                    chk("t3_idle3", bus.HTRANS, 0);
                    chk("t3_hold3", bus.HADDR, 32'h104);
                    bus.HREADY = 1'b0;
                end
                4, 5: begin
                    chk("t3_norsp", bus.rsp_valid, 0);
                    chk("t3_nodup", bus.HTRANS, 0);
                    chk("t3_hold", bus.HADDR, 32'h104);
                    if (c == 5)
                        bus.HREADY = 1'b1;
                end
                6: begin
                    chk("t3_rsp2", bus.rsp_valid, 1);
                    chk("t3_rd2", bus.rsp_rdata, 32'h104);
                end
                7: chk("t3_pulse", bus.rsp_valid, 0);
                default: ;
            endcase
        end
        drain("t3_drain");

        // FIFO full under a stalled bus
        bus.HREADY = 1'b0;
        acc = 0;
        for (int c = 0; c < 8; c++) begin
            if (bus.cmd_ready)
                drive(32'h300 + 32'(acc * 4), 1'b0, 2'd2, 32'h0);
            else
                idle_cmd;
            tick;
            if (bus.cmd_valid)
                acc++;
        end
        idle_cmd;
        chk("t4_accepted", 32'(acc), 5);
        chk("t4_ready_low", bus.cmd_ready, 0);
        chk("t4_stall_ns", bus.HTRANS, 2);
        bus.HREADY = 1'b1;
        got = 0;
        for (int c = 0; c < 30 && got < 6; c++) begin
            if (acc < 6 && bus.cmd_ready)
                drive(32'h300 + 32'(acc * 4), 1'b0, 2'd2, 32'h0);
            else
                idle_cmd;
            tick;
            if (bus.cmd_valid)
                acc++;
            if (bus.rsp_valid) begin
                chk("t4_rdata", bus.rsp_rdata, 32'h300 + 32'(got * 4));
                got++;
            end
        end
        idle_cmd;
        chk("t4_count", 32'(got), 6);
        drain("t4_drain");

`ifdef AHBL_MASTER_ERR_EN
        // ERROR on a read with a write waiting in A
        drive(32'h4000_0000, 1'b0, 2'd2, 32'h0);
        tick;
        drive(32'h4000_0004, 1'b1, 2'd2, 32'h1234_5678);
        tick;
        idle_cmd;
        tick;
        chk("t5_wr_ns", bus.HTRANS, 2);
        bus.HREADY = 1'b0;
        bus.HRESP  = 1'b1;
        #1;
        chk("t5_err1_idle", bus.HTRANS, 0);
        tick;
        bus.HREADY = 1'b1;
        #1;
        chk("t5_err2_idle", bus.HTRANS, 0);
        chk("t5_err2_norsp", bus.rsp_valid, 0);
        tick;
        bus.HRESP = 1'b0;
        #1;
        chk("t5_rsp", bus.rsp_valid, 1);
        chk("t5_err", bus.rsp_err, 1);
        chk("t5_rdata0", bus.rsp_rdata, 0);
        chk("t5_reissue", bus.HTRANS, 2);
        chk("t5_re_addr", bus.HADDR, 32'h4000_0004);
        chk("t5_re_wr", bus.HWRITE, 1);
        tick;
        chk("t5_hwdata", bus.HWDATA, 32'h1234_5678);
        chk("t5_dp_idle", bus.HTRANS, 0);
        chk("t5_dp_norsp", bus.rsp_valid, 0);
        tick;
        chk("t5_wr_rsp", bus.rsp_valid, 1);
        chk("t5_wr_err", bus.rsp_err, 0);
        drain("t5_drain");
`else
        // HRESP is ignored in this build
        drive(32'h700, 1'b0, 2'd2, 32'h0);
        tick;
        idle_cmd;
        tick;
        tick;
        bus.HRESP = 1'b1;
        tick;
        bus.HRESP = 1'b0;
        chk("t5_rsp", bus.rsp_valid, 1);
        chk("t5_noerr", bus.rsp_err, 0);
        chk("t5_rdata", bus.rsp_rdata, 32'h700);
        drain("t5_drain");
`endif

        // reset in the middle of a data phase
        drive(32'h500, 1'b1, 2'd2, 32'hAAAA_5555);
        tick;
        drive(32'h504, 1'b1, 2'd2, 32'h1111_2222);
        tick;
        idle_cmd;
        tick;
        chk("t6_pre_ns", bus.HTRANS, 2);
        HRESET = 1'b1;
        #1;
        chk("t6_htrans", bus.HTRANS, 0);
        chk("t6_haddr", bus.HADDR, 0);
        chk("t6_hwdata", bus.HWDATA, 0);
        chk("t6_busy", bus.busy, 0);
        chk("t6_rsp", bus.rsp_valid, 0);
        tick;
        tick;
        HRESET = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick;
            chk("t6_no_rsp", bus.rsp_valid, 0);
            chk("t6_no_busy", bus.busy, 0);
        end
        drive(32'h600, 1'b0, 2'd2, 32'h0);
        tick;
        idle_cmd;
        tick;
        chk("t6_ns", bus.HTRANS, 2);
        chk("t6_addr", bus.HADDR, 32'h600);
        tick;
        tick;
        chk("t6_new_rsp", bus.rsp_valid, 1);
        chk("t6_new_rd", bus.rsp_rdata, 32'h600);
        drain("t6_drain");

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
